target_round_ctrl: RTL and testbench
====================================

Name: target_round_ctrl

Overview:
- Consumes the 4-bit pseudo-random stream from the game's LFSR and turns it into reflex-game rounds.
- Each round: pick a valid, non-repeating target, light its LED, time the player's button response and score it.
- Sits between the random source, the debounced button inputs and the LED/score display logic.

Parameters:
NUM_TARGETS, 10, number of LED/button pairs; range 2..16
CLK_HZ, 50000000, clk frequency, used to derive the 1 ms tick
TIMEOUT_MS, 1000, response window per round in ms; maximum 65535
GAP_MS, 250, dark interval between rounds in ms
ROUNDS, 10, rounds per game; range 1..15

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
start  in  1  one-cycle start pulse; ignored unless idle
rnd_in  in  4  free-running random value, sampled as needed
btn  in  NUM_TARGETS  synchronized, debounced button levels, 1 = pressed
target_led  out  NUM_TARGETS  one-hot target LED, 0 when not armed
busy  out  1  high from accepted start until DONE exits
round_idx  out  4  current round number, 0-based
score  out  8  hit count, saturating at 255
last_rt_ms  out  16  reaction time of the most recent round
hit  out  1  one-cycle pulse on a correct press
miss  out  1  one-cycle pulse on a wrong press or timeout
done  out  1  one-cycle pulse at game end

Behaviour:
- Reset (asynchronous): state IDLE; all outputs 0; prev_target marked invalid; ms divider and counters cleared. Reset mid-round aborts the game immediately.
- ms tick: divider counts 0..CLK_HZ/1000-1 and emits a 1-cycle tick at terminal count. It is cleared on every state entry, so each interval starts at a full ms.
- btn_q: btn registered every cycle. A press event is press = btn & ~btn_q.
- IDLE -> on start: score=0, round_idx=0, last_rt_ms=0, prev invalid, busy=1; go to DRAW.
- DRAW: sample rnd_in each cycle.
  - Accept when rnd_in < NUM_TARGETS and (prev invalid or rnd_in != prev).
  - After 16 consecutive rejects, force target = (prev+1) mod NUM_TARGETS, or 0 if prev invalid.
  - On accept or force: latch target, set prev=target, go to RELEASE.
- RELEASE: wait until btn == 0, so a held button cannot score; then go to ARMED.
- ARMED: target_led = 1<<target; rt counter starts at 0 and increments on each tick.
  - Any nonzero press: hit if press == 1<<target and (btn & ~(1<<target)) == 0; otherwise miss. last_rt_ms = rt.
  - If rt reaches TIMEOUT_MS with no press: miss, last_rt_ms = TIMEOUT_MS.
  - A press in the same cycle as the timeout is evaluated as a press; the press wins.
- RESULT: one cycle. target_led=0; hit or miss pulses this cycle. On hit, score+1, saturating at 255.
  - If round_idx == ROUNDS-1, go to DONE.
  - Otherwise round_idx+1 and go to GAP.
- GAP: LEDs dark for GAP_MS ticks, then go to DRAW.
- DONE: done=1 for one cycle, busy=0, go to IDLE. score, round_idx and last_rt_ms hold until the next start.
- start outside IDLE is ignored. Button activity outside ARMED only affects btn_q and the RELEASE wait.
- hit, miss and done are mutually exclusive and never asserted in the same cycle.

Decomposition:
- Shared package (game_pkg):
  - state enum: IDLE, DRAW, RELEASE, ARMED, RESULT, GAP, DONE.
  - constant MAX_TARGETS=16.
  - constant DRAW_RETRY_LIMIT=16.
  - function computing ms divider terminal count from CLK_HZ.
- One sub-module: ms_tick_gen (params CLK_HZ; inputs clk, reset, clear; output tick). It is reused by other timed game blocks.

Test Plan:
- Bench params: CLK_HZ=10000 (10 cycles/ms), NUM_TARGETS=10, TIMEOUT_MS=20, GAP_MS=3, ROUNDS=3.
- Reset mid-ARMED at rt=5 -> next cycle target_led=0, busy=0, score=0, state IDLE; a later start begins at round_idx=0.
- rnd_in sequence 12,15,4 after start -> target_led=0x010 (bit 4) on the RELEASE->ARMED transition. Press btn[4] 7 ms later -> hit pulse, score=1, last_rt_ms=7.
- Next round, rnd_in held at 4 (repeat) for 16 cycles -> forced target 5, target_led=0x020.
- Press btn[2] while target is 5 -> miss, score unchanged. Press btn[5] and btn[6] in the same cycle -> miss.
- No press in ARMED -> miss exactly at rt=20, last_rt_ms=20, then GAP lasting 30 cycles.
- btn[3] held from GAP into the next round -> no ARMED entry until release. After 3 rounds: done pulse, busy=0, score held; a start pulse while busy has no effect.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the reflex-game blocks.
// Provides the round FSM state encoding and the 1 ms divider helper.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRAW,
    RELEASE,
    ARMED,
    RESULT,
    GAP,
    DONE
  } state_e;

  localparam int MAX_TARGETS      = 16;
  localparam int DRAW_RETRY_LIMIT = 16;

  // Last count value of a divider that wraps once per millisecond.
  function automatic int ms_terminal_count(input int clk_hz);
    return (clk_hz / 1000) - 1;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick generator: one-cycle pulse every CLK_HZ/1000 cycles.
// Asserting clear makes the current cycle count zero, restarting a full interval.
module ms_tick_gen
  import game_pkg::*;
#(
  parameter int CLK_HZ = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int TC = ms_terminal_count(CLK_HZ);
  localparam int CW = (TC > 0) ? $clog2(TC + 1) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_cur;

  assign cnt_cur = clear ? '0 : cnt_q;
  assign tick    = (cnt_cur == CW'(TC));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= tick ? '0 : cnt_cur + CW'(1);
    end
  end

endmodule

// File: rtl/target_round_ctrl.sv
// Reflex-game round controller: draws non-repeating targets from the LFSR stream,
// lights the target LED, times the button response and keeps the score.
module target_round_ctrl
  import game_pkg::*;
#(
  parameter int NUM_TARGETS = 10,
  parameter int CLK_HZ      = 50000000,
  parameter int TIMEOUT_MS  = 1000,
  parameter int GAP_MS      = 250,
  parameter int ROUNDS      = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             rnd_in,
  input  logic [NUM_TARGETS-1:0] btn,
  output logic [NUM_TARGETS-1:0] target_led,
  output logic                   busy,
  output logic [3:0]             round_idx,
  output logic [7:0]             score,
  output logic [15:0]            last_rt_ms,
  output logic                   hit,
  output logic                   miss,
  output logic                   done
);

  localparam logic [3:0]  LAST_ROUND = 4'(ROUNDS - 1);
  localparam logic [3:0]  LAST_TGT   = 4'(NUM_TARGETS - 1);
  localparam logic [4:0]  NUM_TGT5   = 5'(NUM_TARGETS);
  localparam logic [15:0] TIMEOUT    = 16'(TIMEOUT_MS);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_MS - 1);
  localparam logic [4:0]  RETRY_LAST = 5'(DRAW_RETRY_LIMIT - 1);

  state_e                 state_q;
  logic                   entry_q;
  logic [NUM_TARGETS-1:0] btn_q;
  logic [NUM_TARGETS-1:0] led_q;
  logic [3:0]             target_q;
  logic [3:0]             prev_q;
  logic                   prev_valid_q;
  logic [4:0]             retry_q;
  logic [15:0]            rt_q;
  logic [15:0]            gap_q;
  logic [3:0]             round_q;
  logic [7:0]             score_q;
  logic [15:0]            last_rt_q;
  logic                   busy_q;
  logic                   hit_q;
  logic                   miss_q;
  logic                   done_q;

  logic                   tick;
  logic [NUM_TARGETS-1:0] tgt_mask;
  logic [NUM_TARGETS-1:0] press;
  logic                   press_any;
  logic                   press_hit;
  logic                   rnd_ok;
  logic [3:0]             forced_tgt;
  logic [3:0]             draw_tgt;

  ms_tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(entry_q),
    .tick (tick)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TARGETS; gi++) begin : g_mask
      assign tgt_mask[gi] = (target_q == 4'(gi));
    end
  endgenerate

  assign press     = btn & ~btn_q;
  assign press_any = |press;
  // A correct press must be the only button down, not just the only new edge.
  assign press_hit = (press == tgt_mask) && ((btn & ~tgt_mask) == '0);

  assign rnd_ok     = ({1'b0, rnd_in} < NUM_TGT5) && (!prev_valid_q || (rnd_in != prev_q));
  assign forced_tgt = (!prev_valid_q || (prev_q == LAST_TGT)) ? 4'd0 : prev_q + 4'd1;
  assign draw_tgt   = rnd_ok ? rnd_in : forced_tgt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_q <= '0;
    end else begin
      btn_q <= btn;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      entry_q      <= 1'b1;
      led_q        <= '0;
      target_q     <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      retry_q      <= '0;
      rt_q         <= '0;
      gap_q        <= '0;
      round_q      <= '0;
      score_q      <= '0;
      last_rt_q    <= '0;
      busy_q       <= 1'b0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      entry_q <= 1'b0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            score_q      <= '0;
            round_q      <= '0;
            last_rt_q    <= '0;
            prev_valid_q <= 1'b0;
            busy_q       <= 1'b1;
            retry_q      <= '0;
            state_q      <= DRAW;
            entry_q      <= 1'b1;
          end
        end
        DRAW: begin
          if (rnd_ok || (retry_q == RETRY_LAST)) begin
            target_q     <= draw_tgt;
            prev_q       <= draw_tgt;
            prev_valid_q <= 1'b1;
            state_q      <= RELEASE;
            entry_q      <= 1'b1;
          end else begin
            retry_q <= retry_q + 5'd1;
          end
        end
        RELEASE: begin
          if (btn == '0) begin
            led_q   <= tgt_mask;
            rt_q    <= '0;
            state_q <= ARMED;
            entry_q <= 1'b1;
          end
        end
        ARMED: begin
          // Press is checked first so a press on the timeout cycle still counts.
          if (press_any) begin
            hit_q     <= press_hit;
            miss_q    <= !press_hit;
            last_rt_q <= rt_q;
            if (press_hit && (score_q != 8'hFF)) begin
              score_q <= score_q + 8'd1;
            end
            led_q   <= '0;
            state_q <= RESULT;
            entry_q <= 1'b1;
          end else if (rt_q == TIMEOUT) begin
            miss_q    <= 1'b1;
            last_rt_q <= TIMEOUT;
            led_q     <= '0;
            state_q   <= RESULT;
            entry_q   <= 1'b1;
          end else if (tick) begin
            rt_q <= rt_q + 16'd1;
          end
        end
        RESULT: begin
          entry_q <= 1'b1;
          if (round_q == LAST_ROUND) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            round_q <= round_q + 4'd1;
            gap_q   <= '0;
            state_q <= GAP;
          end
        end
        GAP: begin
          if (tick) begin
            if (gap_q == GAP_LAST) begin
              retry_q <= '0;
              state_q <= DRAW;
              entry_q <= 1'b1;
            end else begin
              gap_q <= gap_q + 16'd1;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
          entry_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          entry_q <= 1'b1;
        end
      endcase
    end
  end

  assign target_led = led_q;
  assign busy       = busy_q;
  assign round_idx  = round_q;
  assign score      = score_q;
  assign last_rt_ms = last_rt_q;
  assign hit        = hit_q;
  assign miss       = miss_q;
  assign done       = done_q;

endmodule

// File: tb/tb_target_round_ctrl.sv
// Directed bench for target_round_ctrl: table of rounds plus hand-written
// sequences for reset abort, held-button release wait and game end.
module tb_target_round_ctrl;

  localparam int NT     = 10;
  localparam int CLK_HZ = 10000;
  localparam int TO_MS  = 20;
  localparam int GAP_MS = 3;
  localparam int ROUNDS = 3;
  localparam int CPM    = CLK_HZ / 1000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    rnd_in = 4'd0;
  logic [NT-1:0] btn = '0;
  logic [NT-1:0] target_led;
  logic          busy;
  logic [3:0]    round_idx;
  logic [7:0]    score;
  logic [15:0]   last_rt_ms;
  logic          hit;
  logic          miss;
  logic          done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  target_round_ctrl #(
    .NUM_TARGETS(NT),
    .CLK_HZ     (CLK_HZ),
    .TIMEOUT_MS (TO_MS),
    .GAP_MS     (GAP_MS),
    .ROUNDS     (ROUNDS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rnd_in    (rnd_in),
    .btn       (btn),
    .target_led(target_led),
    .busy      (busy),
    .round_idx (round_idx),
    .score     (score),
    .last_rt_ms(last_rt_ms),
    .hit       (hit),
    .miss      (miss),
    .done      (done)
  );

  typedef struct {
    logic [3:0]    r0;
    logic [3:0]    r1;
    logic [3:0]    r2;
    logic [NT-1:0] press_mask;
    int            press_cyc;
    logic [NT-1:0] post_btn;
    int            exp_wait;
    logic [NT-1:0] exp_led;
    int            exp_res;
    logic          exp_hit;
    logic [7:0]    exp_score;
    logic [15:0]   exp_rt;
  } round_t;

  round_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Runs one round from a negedge in IDLE (r==0) or the previous RESULT cycle.
  task automatic run_round(input round_t rc, input int r);
    int d;
    int k;
    int idx;
    d = (r == 0) ? 0 : GAP_MS * CPM;
    k = 0;
    if (r == 0) start = 1'b1;
    while (target_led == '0 && k < 200) begin
      @(negedge clk);
      k++;
      if (r == 0 && k == 1) begin
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_round", round_idx, 0);
        chk("start_score", score, 0);
        chk("start_rt", last_rt_ms, 0);
      end
      if (target_led == '0)
        rnd_in = (k <= d + 1) ? rc.r0 : (k == d + 2) ? rc.r1 : rc.r2;
    end
    chk("arm_wait", k, rc.exp_wait);
    chk("arm_led", target_led, rc.exp_led);
    chk("arm_round", round_idx, r);
    idx = 1;
    while (!(hit || miss) && idx < 400) begin
      if (idx == rc.press_cyc) btn = rc.press_mask;
      @(negedge clk);
      idx++;
    end
    chk("res_cycle", idx, rc.exp_res);
    chk("res_hit", hit, rc.exp_hit);
    chk("res_miss", miss, !rc.exp_hit);
    chk("res_score", score, rc.exp_score);
    chk("res_rt", last_rt_ms, rc.exp_rt);
    chk("res_led", target_led, 0);
    chk("res_done", done, 0);
    $display("round %0d: led=%0h wait=%0d hit=%0b miss=%0b score=%0d rt=%0d",
             r, rc.exp_led, k, hit, miss, score, last_rt_ms);
    btn = rc.post_btn;
  endtask

  task automatic check_done(input logic [7:0] exp_score, input logic [15:0] exp_rt);
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("done_nohit", hit | miss, 0);
    @(negedge clk);
    chk("done_low", done, 0);
    chk("idle_busy", busy, 0);
    chk("held_score", score, exp_score);
    chk("held_round", round_idx, ROUNDS - 1);
    chk("held_rt", last_rt_ms, exp_rt);
    $display("game end: score=%0d round=%0d rt=%0d", score, round_idx, last_rt_ms);
  endtask

  always @(negedge clk) begin
    if (!reset) chk("exclusive", (32'(hit) + 32'(miss) + 32'(done)) <= 1, 1);
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit seen_led;

    tbl[0] = '{4'd12, 4'd15, 4'd4, 10'h010, 75,  10'h000, 5,  10'h010, 76,  1'b1, 8'd1, 16'd7};
    tbl[1] = '{4'd4,  4'd4,  4'd4, 10'h004, 33,  10'h000, 48, 10'h020, 34,  1'b0, 8'd1, 16'd3};
    tbl[2] = '{4'd8,  4'd8,  4'd8, 10'h000, 0,   10'h000, 33, 10'h100, 202, 1'b0, 8'd1, 16'd20};
    tbl[3] = '{4'd10, 4'd5,  4'd5, 10'h060, 12,  10'h008, 4,  10'h020, 13,  1'b0, 8'd0, 16'd1};
    tbl[4] = '{4'd7,  4'd7,  4'd9, 10'h200, 201, 10'h000, 35, 10'h200, 202, 1'b1, 8'd2, 16'd20};

    repeat (3) @(negedge clk);
    chk("rst_led", target_led, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {hit, miss, done}, 0);
    chk("rst_counts", {round_idx, score, last_rt_ms}, 0);
    reset = 1'b0;

    // Game 1: aborted by reset in the middle of ARMED.
    @(negedge clk);
    start = 1'b1;
    rnd_in = 4'd3;
    @(negedge clk);
    start = 1'b0;
    chk("g1_busy", busy, 1);
    k = 1;
    while (target_led == '0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("g1_led", target_led, 10'h008);
    repeat (54) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_led", target_led, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    chk("abort_score", score, 0);
    chk("abort_round", round_idx, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_idle", {busy, target_led}, 0);
    $display("reset abort: led=%0h busy=%0b", target_led, busy);

    // Game 2: hit, forced redraw with wrong press, timeout.
    for (int i = 0; i < 3; i++) run_round(tbl[i], i);
    check_done(8'd1, 16'd20);

    // Game 3: double press, held button across the gap, press on timeout cycle.
    @(negedge clk);
    run_round(tbl[3], 0);
    rnd_in = 4'd7;
    seen_led = 1'b0;
    for (int j = 1; j <= 71; j++) begin
      @(negedge clk);
      if (target_led != '0) seen_led = 1'b1;
      start = (j == 50);
    end
    start = 1'b0;
    chk("held_no_arm", seen_led, 0);
    chk("held_round1", round_idx, 1);
    chk("held_busy", busy, 1);
    btn = '0;
    @(negedge clk);
    chk("release_led", target_led, 10'h080);
    btn = 10'h080;
    @(negedge clk);
    chk("quick_hit", hit, 1);
    chk("quick_score", score, 1);
    chk("quick_rt", last_rt_ms, 0);
    $display("round 1: held release led=080 hit=%0b score=%0d rt=%0d", hit, score, last_rt_ms);
    btn = '0;
    run_round(tbl[4], 2);
    check_done(8'd2, 16'd20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
